// File: rtl/am9513_ctx_spill_engine.sv
// Context spill/fill engine: moves one FPU context (rm, flags, rf[0..15]) between the
// context file and a 17-beat stream frame, header first, registers in ascending order.
module am9513_ctx_spill_engine #(
    parameter int NUM_CONTEXTS = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [15:0] cmd_ctx,

    output logic        busy,
    output logic        done_pulse,
    output logic        err_pulse,

    output logic [15:0] ctx_sel,
    output logic [3:0]  rf_index,
    input  logic [1:0]  rm_rdata,
    input  logic [4:0]  flags_rdata,
    input  logic [63:0] rf_rdata,

    output logic        rm_we,
    output logic [1:0]  rm_wdata,
    output logic        flags_clr_we,
    output logic [4:0]  flags_clr_mask,
    output logic        flags_or_we,
    output logic [4:0]  flags_or_mask,
    output logic        rf_we,
    output logic [63:0] rf_wdata,

    output logic        sv_valid,
    input  logic        sv_ready,
    output logic [63:0] sv_data,
    output logic        sv_last,

    input  logic        rs_valid,
    output logic        rs_ready,
    input  logic [63:0] rs_data,
    input  logic        rs_last
);

    typedef enum logic [2:0] {
        IDLE,
        SV_HDR,
        SV_RF,
        RS_HDR,
        RS_FLAGS,
        RS_RF
    } state_t;

    localparam logic [4:0]  LAST_BEAT = 5'd16;
    // One extra bit so a NUM_CONTEXTS of 65536 still compares correctly.
    localparam logic [16:0] CTX_LIMIT = 17'(NUM_CONTEXTS);

    state_t      state_q, state_d;
    logic [4:0]  beat_q, beat_d;
    logic [15:0] ctx_q, ctx_d;
    logic [4:0]  flags_q, flags_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        ctx_ok;
    logic [4:0]  beat_m1;

    assign ctx_ok  = ({1'b0, cmd_ctx} < CTX_LIMIT);
    assign beat_m1 = beat_q - 5'd1;

    assign done_pulse = done_q;
    assign err_pulse  = err_q;

    // NOTE: state is updated with non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            ctx_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ctx_q   <= ctx_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every output and next-state variable gets a default before the case
    // statement, so no path through this block can infer a latch.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        ctx_d          = ctx_q;
        flags_d        = flags_q;
        done_d         = 1'b0;
        err_d          = 1'b0;

        cmd_ready      = 1'b0;
        busy           = 1'b1;
        ctx_sel        = ctx_q;
        rf_index       = 4'd0;

        sv_valid       = 1'b0;
        sv_data        = '0;
        sv_last        = 1'b0;
        rs_ready       = 1'b0;

        rm_we          = 1'b0;
        rm_wdata       = '0;
        flags_clr_we   = 1'b0;
        flags_clr_mask = '0;
        flags_or_we    = 1'b0;
        flags_or_mask  = '0;
        rf_we          = 1'b0;
        rf_wdata       = '0;

        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                ctx_sel   = '0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (ctx_ok) begin
                        ctx_d   = cmd_ctx;
                        beat_d  = '0;
                        state_d = cmd_op ? RS_HDR : SV_HDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SV_HDR: begin
                sv_valid = 1'b1;
                sv_data  = {57'b0, flags_rdata, rm_rdata};
                if (sv_ready) begin
                    beat_d  = 5'd1;
                    state_d = SV_RF;
                end
            end

            SV_RF: begin
                rf_index = beat_m1[3:0];
                sv_valid = 1'b1;
                sv_data  = rf_rdata;
                sv_last  = (beat_q == LAST_BEAT);
                if (sv_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end
            end

            RS_HDR: begin
                rs_ready = 1'b1;
                if (rs_valid) begin
                    rm_we          = 1'b1;
                    rm_wdata       = rs_data[1:0];
                    flags_clr_we   = 1'b1;
                    flags_clr_mask = 5'h1F;
                    flags_d        = rs_data[6:2];
                    if (rs_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RS_FLAGS;
                    end
                end
            end

            // Separate cycle so the OR can never collide with the clear.
            RS_FLAGS: begin
                flags_or_we   = 1'b1;
                flags_or_mask = flags_q;
                beat_d        = 5'd1;
                state_d       = RS_RF;
            end

            RS_RF: begin
                rf_index = beat_m1[3:0];
                rs_ready = 1'b1;
                if (rs_valid) begin
                    rf_we    = 1'b1;
                    rf_wdata = rs_data;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        done_d  = 1'b1;
                        err_d   = ~rs_last;
                        state_d = IDLE;
                    end else if (rs_last) begin
                        beat_d  = '0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end
            end

            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
